rule_scan_ctrl: RTL and testbench
=================================

# rule_scan_ctrl

Sequencer that classifies one packet at a time against a configurable rule table by scanning it with `rule_match` comparators, LANES rules per cycle. It returns the lowest-index enabled rule whose ranges contain the packet, or a miss. It sits between the packet ingress handshake and the downstream action stage, and it owns the rule table storage and its configuration port.

## Interface
- NUM_RULES, 16: rule table depth; must be a multiple of LANES.
- LANES, 4: rules compared per SCAN cycle (number of `rule_match` instances).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  packet offered.
- in_ready  out  1  controller can accept a packet.
- in_packet  in  packet_s  header to classify.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_hit  out  1  1 = a rule matched.
- out_rule_idx  out  $clog2(NUM_RULES)  index of the matching rule; 0 on miss.
- cfg_we  in  1  write one table entry.
- cfg_ready  out  1  table writable this cycle.
- cfg_addr  in  $clog2(NUM_RULES)  entry index.
- cfg_rule  in  rule_s  start/last bounds of the entry.
- cfg_enable  in  1  entry enable bit written alongside the rule.

## Operation
- Table: NUM_RULES × (rule_s + enable bit). Reset clears all enable bits; rule contents are not reset.
- Match semantics are per field: start ≤ value < last, applied to protocol, src ip/port, and dst ip/port. An entry with start ≥ last in any field never matches.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: in_ready=1, cfg_ready=1. When in_valid is high, latch in_packet, set group=0, and go to SCAN.
  - SCAN: compare entries group·LANES … group·LANES+LANES-1 against the latched packet. Any enabled match: record the lowest matching index, set hit=1, go to DONE. No match and this is the last group: set hit=0, idx=0, go to DONE. Otherwise group+1.
  - DONE: out_valid=1. out_hit and out_rule_idx are stable until the handshake. When out_ready is high, go to IDLE.
- Config writes take effect only when cfg_we && cfg_ready. cfg_ready=0 in SCAN and DONE, so the table is frozen for the duration of a classification.
- cfg_addr ≥ NUM_RULES: the write is ignored.
- Writes to the same address in different cycles: last write wins.

## Timing
- Reset values: state IDLE, in_ready=1, cfg_ready=1, out_valid=0, out_hit=0, out_rule_idx=0, group=0.
- Packet accepted at edge E0.
  - A hit in group g: out_valid is high after edge E(g+1).
  - A full miss: out_valid is high after edge E(NUM_RULES/LANES).
- The result handshake at edge Ek returns the block to IDLE. in_ready is high from the next cycle; there is no same-cycle bypass.
- Minimum packet period: (groups scanned) + 2 cycles.
- cfg_we and in_valid in the same IDLE cycle: both are accepted. The written entry is visible to that packet's scan.
- out_ready held high before DONE has no effect. out_valid never drops without a handshake.
- rst asserted mid-SCAN or mid-DONE: immediate return to reset values. The in-flight packet is discarded and no result is emitted.
- Width rule: group counter is $clog2(NUM_RULES/LANES) bits, with a minimum of 1. out_rule_idx = group·LANES + lane offset, with no truncation.

## Structure
- rule_s, packet_s, PROTOCOL_SIZE, IP_SIZE, PORT_SIZE: existing definitions in network_pkg.
- Add to network_pkg: scan_state_e (IDLE/SCAN/DONE).
- Sub-module: `rule_match`, instantiated LANES times, fed by a mux that selects the current group.
- Lowest-index priority encoder across lanes: inline.

## Test plan
- Reset, table empty, classify any packet → out_valid after E4 (NUM_RULES=16, LANES=4), out_hit=0, out_rule_idx=0.
- Rule 5: proto [6,7), src ip [10.0.0.0,10.0.1.0), ports [0,65535), dst [0,max); packet proto 6, src 10.0.0.7 → hit, idx=5, out_valid after E2.
- Rules 2 and 9 both match the packet → idx=2. Disable rule 2 via cfg_enable=0 → idx=9, out_valid after E3.
- Boundary: dst port equal to last → miss. Dst port equal to start → hit. Rule with start=last → never hits.
- out_ready low for 5 cycles in DONE → outputs held, in_ready=0, cfg_ready=0. A cfg_we issued in that window is ignored.
- rst pulsed during SCAN → out_valid stays 0 and all enables are cleared. The next packet misses.

Source files
------------

// File: rtl/network_pkg.sv
// Shared packet/rule header types for the classifier path, plus the scan
// sequencer state encoding.
package network_pkg;

  localparam int PROTOCOL_SIZE = 8;
  localparam int IP_SIZE       = 32;
  localparam int PORT_SIZE     = 16;

  typedef struct packed {
    logic [PROTOCOL_SIZE-1:0] protocol;
    logic [IP_SIZE-1:0]       src_ip;
    logic [PORT_SIZE-1:0]     src_port;
    logic [IP_SIZE-1:0]       dst_ip;
    logic [PORT_SIZE-1:0]     dst_port;
  } packet_s;

  // Each field matches when start <= value < last.
  typedef struct packed {
    logic [PROTOCOL_SIZE-1:0] protocol_start;
    logic [PROTOCOL_SIZE-1:0] protocol_last;
    logic [IP_SIZE-1:0]       src_ip_start;
    logic [IP_SIZE-1:0]       src_ip_last;
    logic [PORT_SIZE-1:0]     src_port_start;
    logic [PORT_SIZE-1:0]     src_port_last;
    logic [IP_SIZE-1:0]       dst_ip_start;
    logic [IP_SIZE-1:0]       dst_ip_last;
    logic [PORT_SIZE-1:0]     dst_port_start;
    logic [PORT_SIZE-1:0]     dst_port_last;
  } rule_s;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } scan_state_e;

  function automatic int clog2Min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/rule_scan_ctrl_if.sv
// Packet ingress, result egress and table configuration signals of the
// rule scan controller.
interface rule_scan_ctrl_if import network_pkg::*; #(
  parameter int NUM_RULES = 16
);

  localparam int IDX_W = clog2Min1(NUM_RULES);

  logic             in_valid;
  logic             in_ready;
  packet_s          in_packet;
  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic [IDX_W-1:0] out_rule_idx;
  logic             cfg_we;
  logic             cfg_ready;
  logic [IDX_W-1:0] cfg_addr;
  rule_s            cfg_rule;
  logic             cfg_enable;

  modport slave (
    input  in_valid, in_packet, out_ready, cfg_we, cfg_addr, cfg_rule, cfg_enable,
    output in_ready, out_valid, out_hit, out_rule_idx, cfg_ready
  );

  modport master (
    output in_valid, in_packet, out_ready, cfg_we, cfg_addr, cfg_rule, cfg_enable,
    input  in_ready, out_valid, out_hit, out_rule_idx, cfg_ready
  );

endinterface

// File: rtl/rule_scan_ctrl_match.sv
// Single-entry comparator: checks one rule's five half-open ranges against a
// packet header, gated by the entry's enable bit.
module rule_match import network_pkg::*; (
  input  rule_s   i_rule,
  input  logic    i_enable,
  input  packet_s i_packet,
  output logic    o_match
);

  logic w_proto;
  logic w_srcIp;
  logic w_srcPort;
  logic w_dstIp;
  logic w_dstPort;

  // A field with start >= last can never satisfy both bounds.
  assign w_proto   = (i_packet.protocol >= i_rule.protocol_start) &&
                     (i_packet.protocol <  i_rule.protocol_last);
  assign w_srcIp   = (i_packet.src_ip   >= i_rule.src_ip_start) &&
                     (i_packet.src_ip   <  i_rule.src_ip_last);
  assign w_srcPort = (i_packet.src_port >= i_rule.src_port_start) &&
                     (i_packet.src_port <  i_rule.src_port_last);
  assign w_dstIp   = (i_packet.dst_ip   >= i_rule.dst_ip_start) &&
                     (i_packet.dst_ip   <  i_rule.dst_ip_last);
  assign w_dstPort = (i_packet.dst_port >= i_rule.dst_port_start) &&
                     (i_packet.dst_port <  i_rule.dst_port_last);

  assign o_match = i_enable && w_proto && w_srcIp && w_srcPort && w_dstIp && w_dstPort;

endmodule

// File: rtl/rule_scan_ctrl.sv
// Classifies one packet at a time by scanning the rule table LANES entries per
// cycle and reporting the lowest-index enabled match.
module rule_scan_ctrl import network_pkg::*; #(
  parameter int NUM_RULES = 16,
  parameter int LANES     = 4
) (
  input logic             clk,
  input logic             rst,
  rule_scan_ctrl_if.slave bus
);

  localparam int IDX_W      = clog2Min1(NUM_RULES);
  localparam int NUM_GROUPS = NUM_RULES / LANES;
  localparam int GRP_W      = clog2Min1(NUM_GROUPS);
  localparam logic [GRP_W-1:0] LAST_GROUP = GRP_W'(NUM_GROUPS - 1);

  rule_s                r_rules [NUM_RULES];
  logic [NUM_RULES-1:0] r_enable;
  scan_state_e          r_state;
  logic [GRP_W-1:0]     r_group;
  packet_s              r_packet;
  logic                 r_inReady;
  logic                 r_cfgReady;
  logic                 r_outValid;
  logic                 r_outHit;
  logic [IDX_W-1:0]     r_outIdx;

  logic             w_cfgWrite;
  rule_s            w_laneRule [LANES];
  logic [LANES-1:0] w_laneEn;
  logic [LANES-1:0] w_laneMatch;
  logic [IDX_W-1:0] w_laneIdx [LANES];
  logic             w_anyMatch;
  logic [IDX_W-1:0] w_matchIdx;

  assign w_cfgWrite = bus.cfg_we && r_cfgReady &&
                      ({1'b0, bus.cfg_addr} < (IDX_W+1)'(NUM_RULES));

  assign bus.in_ready     = r_inReady;
  assign bus.cfg_ready    = r_cfgReady;
  assign bus.out_valid    = r_outValid;
  assign bus.out_hit      = r_outHit;
  assign bus.out_rule_idx = r_outIdx;

  // Rule contents carry no reset; only the enable bits define an empty table.
  always_ff @(posedge clk) begin
    if (w_cfgWrite) begin
      r_rules[bus.cfg_addr] <= bus.cfg_rule;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enable <= '0;
    end else if (w_cfgWrite) begin
      r_enable[bus.cfg_addr] <= bus.cfg_enable;
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_laneIdx[l]  = IDX_W'(int'(r_group) * LANES + l);
      w_laneRule[l] = r_rules[w_laneIdx[l]];
      w_laneEn[l]   = r_enable[w_laneIdx[l]];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    rule_match u_match (
      .i_rule   (w_laneRule[l]),
      .i_enable (w_laneEn[l]),
      .i_packet (r_packet),
      .o_match  (w_laneMatch[l])
    );
  end

  // Walking down from the top lane leaves the lowest matching lane selected.
  always_comb begin
    w_anyMatch = 1'b0;
    w_matchIdx = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (w_laneMatch[l]) begin
        w_anyMatch = 1'b1;
        w_matchIdx = w_laneIdx[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_group    <= '0;
      r_packet   <= '0;
      r_inReady  <= 1'b1;
      r_cfgReady <= 1'b1;
      r_outValid <= 1'b0;
      r_outHit   <= 1'b0;
      r_outIdx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_packet   <= bus.in_packet;
            r_group    <= '0;
            r_inReady  <= 1'b0;
            r_cfgReady <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          if (w_anyMatch) begin
            r_outHit   <= 1'b1;
            r_outIdx   <= w_matchIdx;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else if (r_group == LAST_GROUP) begin
            r_outHit   <= 1'b0;
            r_outIdx   <= '0;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_group <= r_group + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_cfgReady <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rule_scan_ctrl.sv
// Scoreboard bench for rule_scan_ctrl: a reference table model predicts hit,
// index and result latency for every packet offered.
module tb_rule_scan_ctrl;
  import network_pkg::*;

  localparam int NUM_RULES = 16;
  localparam int LANES     = 4;
  localparam int GROUPS    = NUM_RULES / LANES;
  localparam int MAX_WAIT  = 40;

  typedef struct {
    bit hit;
    int idx;
    int lat;
  } exp_t;

  logic clk;
  logic rst;

  rule_scan_ctrl_if #(.NUM_RULES(NUM_RULES)) bus ();

  rule_scan_ctrl #(.NUM_RULES(NUM_RULES), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  rule_s mRule [NUM_RULES];
  bit    mEn   [NUM_RULES];
  exp_t  expQ  [$];
  int    vecCount;
  int    missCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic rule_s mkRule(
    input logic [7:0]  ps, input logic [7:0]  pl,
    input logic [31:0] sis, input logic [31:0] sil,
    input logic [15:0] sps, input logic [15:0] spl,
    input logic [31:0] dis, input logic [31:0] dil,
    input logic [15:0] dps, input logic [15:0] dpl);
    rule_s r;
    r.protocol_start = ps;  r.protocol_last = pl;
    r.src_ip_start   = sis; r.src_ip_last   = sil;
    r.src_port_start = sps; r.src_port_last = spl;
    r.dst_ip_start   = dis; r.dst_ip_last   = dil;
    r.dst_port_start = dps; r.dst_port_last = dpl;
    return r;
  endfunction

  function automatic packet_s mkPkt(input logic [7:0] proto, input logic [31:0] sip,
                                    input logic [15:0] sport, input logic [31:0] dip,
                                    input logic [15:0] dport);
    packet_s p;
    p.protocol = proto;
    p.src_ip   = sip;
    p.src_port = sport;
    p.dst_ip   = dip;
    p.dst_port = dport;
    return p;
  endfunction

  function automatic bit inRange(input longint v, input longint lo, input longint hi);
    return (v >= lo) && (v < hi);
  endfunction

  function automatic exp_t modelLookup(input packet_s p);
    exp_t e;
    e.hit = 1'b0;
    e.idx = 0;
    e.lat = GROUPS;
    for (int i = 0; i < NUM_RULES; i++) begin
      if (mEn[i] &&
          inRange(longint'(p.protocol), longint'(mRule[i].protocol_start), longint'(mRule[i].protocol_last)) &&
          inRange(longint'(p.src_ip),   longint'(mRule[i].src_ip_start),   longint'(mRule[i].src_ip_last)) &&
          inRange(longint'(p.src_port), longint'(mRule[i].src_port_start), longint'(mRule[i].src_port_last)) &&
          inRange(longint'(p.dst_ip),   longint'(mRule[i].dst_ip_start),   longint'(mRule[i].dst_ip_last)) &&
          inRange(longint'(p.dst_port), longint'(mRule[i].dst_port_start), longint'(mRule[i].dst_port_last))) begin
        e.hit = 1'b1;
        e.idx = i;
        e.lat = i / LANES + 1;
        return e;
      end
    end
    return e;
  endfunction

  task automatic writeRule(input int addr, input rule_s r, input bit en);
    @(negedge clk);
    checkOutput("cfg_ready_idle", bus.cfg_ready, 1);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = addr[3:0];
    bus.cfg_rule   = r;
    bus.cfg_enable = en;
    mRule[addr] = r;
    mEn[addr]   = en;
    @(posedge clk);
    #1;
    bus.cfg_we = 1'b0;
  endtask

  // Offers one packet (optionally with a same-cycle table write), waits for the
  // result, holds out_ready low for 'hold' cycles, then completes the handshake.
  task automatic applyStimulus(input packet_s p, input int hold, input bit doCfg,
                               input int addr, input rule_s r, input bit en);
    exp_t e;
    exp_t got;
    int   lat;
    rule_s junk;
    junk = mkRule(8'd0, 8'hFF, 32'd0, 32'hFFFF_FFFF, 16'd0, 16'hFFFF,
                  32'd0, 32'hFFFF_FFFF, 16'd0, 16'hFFFF);
    @(negedge clk);
    checkOutput("in_ready_idle", bus.in_ready, 1);
    if (doCfg) begin
      bus.cfg_we     = 1'b1;
      bus.cfg_addr   = addr[3:0];
      bus.cfg_rule   = r;
      bus.cfg_enable = en;
      mRule[addr] = r;
      mEn[addr]   = en;
    end
    e = modelLookup(p);
    expQ.push_back(e);
    bus.in_packet = p;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.cfg_we   = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = expQ.pop_front();
    checkOutput("latency", lat, got.lat);
    checkOutput("out_hit", bus.out_hit, 32'(got.hit));
    checkOutput("out_rule_idx", bus.out_rule_idx, got.idx);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", bus.out_valid, 1);
      checkOutput("hold_hit", bus.out_hit, 32'(got.hit));
      checkOutput("hold_idx", bus.out_rule_idx, got.idx);
      checkOutput("hold_in_ready", bus.in_ready, 0);
      checkOutput("hold_cfg_ready", bus.cfg_ready, 0);
      if (i == 1) begin
        bus.cfg_we     = 1'b1;
        bus.cfg_addr   = 4'd0;
        bus.cfg_rule   = junk;
        bus.cfg_enable = 1'b1;
      end else begin
        bus.cfg_we = 1'b0;
      end
    end
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput("post_out_valid", bus.out_valid, 0);
    checkOutput("post_in_ready", bus.in_ready, 1);
  endtask

  task automatic resetMidScan(input packet_s p);
    @(negedge clk);
    bus.in_packet = p;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #2;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_cfg_ready", bus.cfg_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_RULES; i++) mEn[i] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("after_rst_out_valid", bus.out_valid, 0);
    end
  endtask

  initial begin
    rule_s   wide;
    rule_s   r;
    packet_s p;
    rule_s   none;

    vecCount  = 0;
    missCount = 0;
    for (int i = 0; i < NUM_RULES; i++) mEn[i] = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_packet = '0;
    bus.out_ready = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_rule  = '0;
    bus.cfg_enable= 1'b0;
    none = '0;
    wide = mkRule(8'd0, 8'hFF, 32'd0, 32'hFFFF_FFFF, 16'd0, 16'hFFFF,
                  32'd0, 32'hFFFF_FFFF, 16'd0, 16'hFFFF);

    #12;
    checkOutput("reset_in_ready", bus.in_ready, 1);
    checkOutput("reset_cfg_ready", bus.cfg_ready, 1);
    checkOutput("reset_out_valid", bus.out_valid, 0);
    checkOutput("reset_out_hit", bus.out_hit, 0);
    checkOutput("reset_out_rule_idx", bus.out_rule_idx, 0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] empty table miss");
    p = mkPkt(8'd6, 32'h0A00_0007, 16'd1234, 32'h0102_0304, 16'd80);
    applyStimulus(p, 0, 1'b0, 0, none, 1'b0);

    $display("[TB] rule 5 hit");
    r = mkRule(8'd6, 8'd7, 32'h0A00_0000, 32'h0A00_0100, 16'd0, 16'hFFFF,
               32'd0, 32'hFFFF_FFFF, 16'd0, 16'hFFFF);
    writeRule(5, r, 1'b1);
    applyStimulus(p, 0, 1'b0, 0, none, 1'b0);

    $display("[TB] priority between rules 2 and 9");
    r = wide;
    r.protocol_start = 8'd17;
    r.protocol_last  = 8'd18;
    writeRule(2, r, 1'b1);
    writeRule(9, wide, 1'b1);
    p = mkPkt(8'd17, 32'hC0A8_0001, 16'd5000, 32'h0A0A_0A0A, 16'd53);
    applyStimulus(p, 0, 1'b0, 0, none, 1'b0);
    writeRule(2, r, 1'b0);
    applyStimulus(p, 0, 1'b0, 0, none, 1'b0);

    $display("[TB] dst port boundaries");
    writeRule(9, wide, 1'b0);
    r = wide;
    r.dst_port_start = 16'd1000;
    r.dst_port_last  = 16'd2000;
    writeRule(12, r, 1'b1);
    p.dst_port = 16'd2000;
    applyStimulus(p, 0, 1'b0, 0, none, 1'b0);
    p.dst_port = 16'd1000;
    applyStimulus(p, 0, 1'b0, 0, none, 1'b0);
    r = wide;
    r.dst_port_start = 16'd3000;
    r.dst_port_last  = 16'd3000;
    writeRule(13, r, 1'b1);
    p.dst_port = 16'd3000;
    applyStimulus(p, 0, 1'b0, 0, none, 1'b0);

    $display("[TB] result held with out_ready low, cfg write blocked");
    p.dst_port = 16'd1000;
    applyStimulus(p, 5, 1'b0, 0, none, 1'b0);
    applyStimulus(p, 0, 1'b0, 0, none, 1'b0);

    $display("[TB] same-cycle table write and packet");
    p.dst_port = 16'd3000;
    applyStimulus(p, 0, 1'b1, 1, wide, 1'b1);

    $display("[TB] reset during scan");
    resetMidScan(p);
    applyStimulus(p, 0, 1'b0, 0, none, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
